mem_stage_bus_ctrl: RTL and testbench

- Sequences every load/store sitting in the memory stage of the 3-stage pipeline.
- Decodes the address to data memory or UART and runs the access: fixed-latency for data memory, req/ack handshake for UART.
- Holds the E→M pipeline register and upstream stages via stall_o until the access completes, then presents read data for writeback.
- Is the sole owner of the data-memory and UART chip selects.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_addr_decode.sv | 15 +
 rtl/mem_stage_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_stage_bus_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory-stage bus controller and its address decoder.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DM_BUSY   = 2'd1,
        UART_BUSY = 2'd2,
        DONE      = 2'd3
    } state_e;

    typedef enum logic {
        TGT_DM   = 1'b0,
        TGT_UART = 1'b1
    } target_e;

    localparam logic [31:0] UART_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] UART_MASK_DEF = 32'hFFFF_FF00;

    // Wide enough for the largest legal data-memory latency (15).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address-to-target decode; anything outside the UART window is data memory.
module mem_addr_decode
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned    DW        = 32,
    parameter logic [DW-1:0] UART_BASE = DW'(UART_BASE_DEF),
    parameter logic [DW-1:0] UART_MASK = DW'(UART_MASK_DEF)
) (
    input  logic [DW-1:0] addr_i,
    output target_e       target_o
);

    assign target_o = ((addr_i & UART_MASK) == UART_BASE) ? TGT_UART : TGT_DM;

endmodule

// File: rtl/mem_stage_bus_ctrl.sv
// Memory-stage load/store sequencer: fixed-latency data memory or req/ack UART, stalling the pipe meanwhile.
// Optional UART ack timeout with bus_err_o reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_bus_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned    DW        = 32,
    parameter int unsigned    DM_LAT    = 2,
    parameter logic [DW-1:0] UART_BASE = DW'(UART_BASE_DEF),
    parameter logic [DW-1:0] UART_MASK = DW'(UART_MASK_DEF),
    parameter int unsigned    TIMEOUT   = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          stall_o,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic [DW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic          bus_we_o,
    output logic          cs_dm_o,
    input  logic [DW-1:0] dm_rdata_i,
    output logic          uart_req_o,
    input  logic          uart_ack_i,
    input  logic [DW-1:0] uart_rdata_i,
    output logic          bus_err_o
);

    localparam logic [CNT_W-1:0] DM_CNT_INIT = CNT_W'(DM_LAT - 1);

    // Elaboration-time guard on parameter ranges.
    if (DM_LAT < 1 || DM_LAT > 15) begin : g_bad_dm_lat
        $error("mem_stage_bus_ctrl: DM_LAT must be within 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_stage_bus_ctrl: TIMEOUT must be at least 1");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_c;
    target_e          tgt_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
`endif

    assign req_c = mem_read_i | mem_write_i;

    mem_addr_decode #(
        .DW        (DW),
        .UART_BASE (UART_BASE),
        .UART_MASK (UART_MASK)
    ) u_decode (
        .addr_i   (addr_i),
        .target_o (tgt_c)
    );

    // Held low while in reset so an in-flight access releases the pipe immediately.
    assign stall_o = ~rst_i & (((state_q == IDLE) & req_c) |
                               (state_q == DM_BUSY) | (state_q == UART_BUSY));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_we_o    <= 1'b0;
            cs_dm_o     <= 1'b0;
            uart_req_o  <= 1'b0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_err_o   <= 1'b0;
`endif
        end else begin
            rvalid_o  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_o <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        bus_addr_o  <= addr_i;
                        bus_wdata_o <= wdata_i;
                        bus_we_o    <= mem_write_i;
                        if (tgt_c == TGT_UART) begin
                            state_q    <= UART_BUSY;
                            uart_req_o <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt_q  <= '0;
`endif
                        end else begin
                            state_q <= DM_BUSY;
                            cs_dm_o <= 1'b1;
                            cnt_q   <= DM_CNT_INIT;
                        end
                    end
                end
                DM_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        cs_dm_o  <= 1'b0;
                        rvalid_o <= ~bus_we_o;
                        if (!bus_we_o) rdata_o <= dm_rdata_i;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                UART_BUSY: begin
                    if (uart_ack_i) begin
                        state_q    <= DONE;
                        uart_req_o <= 1'b0;
                        rvalid_o   <= ~bus_we_o;
                        if (!bus_we_o) rdata_o <= uart_rdata_i;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Give up on a silent UART; loads return zero and flag the error.
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q    <= DONE;
                        uart_req_o <= 1'b0;
                        rvalid_o   <= ~bus_we_o;
                        bus_err_o  <= 1'b1;
                        if (!bus_we_o) rdata_o <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_bus_ctrl.sv
// Self-checking bench for mem_stage_bus_ctrl: directed scenarios plus randomized accesses vs. a transaction model.
module tb_mem_stage_bus_ctrl;

    localparam int          DM_LAT  = 2;
    localparam int          TIMEOUT = 64;
    localparam int          LIMIT   = 200;
    localparam logic [31:0] U_BASE  = 32'h8000_0000;
    localparam logic [31:0] U_MASK  = 32'hFFFF_FF00;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, rvalid_o, bus_we_o, cs_dm_o, uart_req_o, bus_err_o;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic [31:0] dm_rdata_i = '0, uart_rdata_i = '0;
    logic        uart_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Results of the most recent access as seen by the bench.
    int          r_done_k, r_stall, r_cs, r_req, r_overlap, r_rvalid_cnt, r_err_cnt, r_idle_bad;
    logic [31:0] r_rdata, r_rdata_done, r_bus_addr, r_bus_wdata;
    logic        r_bus_we;
    logic [31:0] dm_hist   [0:LIMIT-1];
    logic [31:0] uart_hist [0:LIMIT-1];
    logic        dm_fixed_en = 1'b0;
    logic [31:0] dm_fixed = '0;
    logic [31:0] exp_last_rdata = '0;

    always #5 clk_i = ~clk_i;

    mem_stage_bus_ctrl #(
        .DW        (32),
        .DM_LAT    (DM_LAT),
        .UART_BASE (U_BASE),
        .UART_MASK (U_MASK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_we_o     (bus_we_o),
        .cs_dm_o      (cs_dm_o),
        .dm_rdata_i   (dm_rdata_i),
        .uart_req_o   (uart_req_o),
        .uart_ack_i   (uart_ack_i),
        .uart_rdata_i (uart_rdata_i),
        .bus_err_o    (bus_err_o)
    );

    // Presents one instruction in M from cycle 0 until the first cycle stall_o is low.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_at);
        r_done_k = -1; r_stall = 0; r_cs = 0; r_req = 0; r_overlap = 0;
        r_rvalid_cnt = 0; r_err_cnt = 0; r_rdata = '0; r_rdata_done = '0;
        r_bus_addr = '0; r_bus_wdata = '0; r_bus_we = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge clk_i); #1;
            mem_read_i   = rd;
            mem_write_i  = wr;
            addr_i       = a;
            wdata_i      = wd;
            dm_rdata_i   = dm_fixed_en ? dm_fixed : 32'($urandom);
            uart_rdata_i = 32'($urandom);
            uart_ack_i   = (k == ack_at);
            dm_hist[k]   = dm_rdata_i;
            uart_hist[k] = uart_rdata_i;
            #1;
            if (stall_o)              r_stall++;
            if (cs_dm_o)              r_cs++;
            if (uart_req_o)           r_req++;
            if (cs_dm_o && uart_req_o) r_overlap++;
            if (bus_err_o)            r_err_cnt++;
            if (rvalid_o) begin
                r_rvalid_cnt++;
                r_rdata = rdata_o;
            end
            if (k == 1) begin
                r_bus_addr  = bus_addr_o;
                r_bus_wdata = bus_wdata_o;
                r_bus_we    = bus_we_o;
            end
            if (!stall_o) begin
                r_done_k     = k;
                r_rdata_done = rdata_o;
                break;
            end
        end
        uart_ack_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic ack);
        r_idle_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
            uart_ack_i  = ack;
            #1;
            if (stall_o || cs_dm_o || uart_req_o || rvalid_o || bus_err_o) r_idle_bad++;
        end
        uart_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        mem_read_i = 1'b1;
        addr_i     = 32'h10;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset.stall got %b want 0", stall_o); end
        checks++; if (cs_dm_o !== 1'b0 || uart_req_o !== 1'b0) begin errors++; $display("FAIL reset.selects got cs=%b req=%b want 0", cs_dm_o, uart_req_o); end
        checks++; if (rvalid_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL reset.flags got rvalid=%b err=%b want 0", rvalid_o, bus_err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset.rdata got %h want 0", rdata_o); end
        checks++; if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_we_o !== 1'b0) begin errors++; $display("FAIL reset.bus got %h/%h/%b want 0", bus_addr_o, bus_wdata_o, bus_we_o); end
        mem_read_i = 1'b0;
        #2 rst_i = 1'b0;
        exp_last_rdata = '0;
    endtask

    task automatic test_dm_load;
        dm_fixed_en = 1'b1;
        dm_fixed    = 32'hDEAD_BEEF;
        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1);
        dm_fixed_en = 1'b0;
        checks++; if (r_done_k !== DM_LAT + 1) begin errors++; $display("FAIL dm_load.latency got %0d want %0d", r_done_k, DM_LAT + 1); end
        checks++; if (r_stall !== DM_LAT + 1) begin errors++; $display("FAIL dm_load.stall_cycles got %0d want %0d", r_stall, DM_LAT + 1); end
        checks++; if (r_cs !== DM_LAT) begin errors++; $display("FAIL dm_load.cs_cycles got %0d want %0d", r_cs, DM_LAT); end
        checks++; if (r_req !== 0) begin errors++; $display("FAIL dm_load.uart_req got %0d want 0", r_req); end
        checks++; if (r_rvalid_cnt !== 1 || r_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dm_load.data got n=%0d %h want 1 deadbeef", r_rvalid_cnt, r_rdata); end
        checks++; if (r_bus_addr !== 32'h10 || r_bus_we !== 1'b0) begin errors++; $display("FAIL dm_load.bus got %h we=%b want 10 0", r_bus_addr, r_bus_we); end
        exp_last_rdata = 32'hDEAD_BEEF;
        idle_cycles(2, 1'b0);
        checks++; if (r_idle_bad !== 0) begin errors++; $display("FAIL dm_load.after_quiet got %0d busy cycles want 0", r_idle_bad); end
        checks++; if (rdata_o !== exp_last_rdata) begin errors++; $display("FAIL dm_load.rdata_hold got %h want %h", rdata_o, exp_last_rdata); end
    endtask

    task automatic test_uart_store;
        run_access(1'b0, 1'b1, 32'h8000_0004, 32'h41, 6);
        checks++; if (r_done_k !== 7) begin errors++; $display("FAIL uart_store.latency got %0d want 7", r_done_k); end
        checks++; if (r_req !== 6 || r_cs !== 0) begin errors++; $display("FAIL uart_store.selects got req=%0d cs=%0d want 6 0", r_req, r_cs); end
        checks++; if (r_bus_we !== 1'b1 || r_bus_wdata !== 32'h41 || r_bus_addr !== 32'h8000_0004) begin errors++; $display("FAIL uart_store.bus got we=%b %h @%h want 1 41 @80000004", r_bus_we, r_bus_wdata, r_bus_addr); end
        checks++; if (r_rvalid_cnt !== 0) begin errors++; $display("FAIL uart_store.rvalid got %0d want 0", r_rvalid_cnt); end
        checks++; if (r_rdata_done !== exp_last_rdata) begin errors++; $display("FAIL uart_store.rdata_kept got %h want %h", r_rdata_done, exp_last_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp1;
        run_access(1'b1, 1'b0, 32'h0000_1234, 32'h0, -1);
        exp1 = dm_hist[DM_LAT];
        checks++; if (r_done_k !== DM_LAT + 1 || r_rvalid_cnt !== 1 || r_rdata !== exp1) begin errors++; $display("FAIL b2b.dm got k=%0d n=%0d %h want %0d 1 %h", r_done_k, r_rvalid_cnt, r_rdata, DM_LAT + 1, exp1); end
        run_access(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1);
        checks++; if (r_done_k !== 2 || r_rvalid_cnt !== 1 || r_rdata !== uart_hist[1]) begin errors++; $display("FAIL b2b.uart got k=%0d n=%0d %h want 2 1 %h", r_done_k, r_rvalid_cnt, r_rdata, uart_hist[1]); end
        exp_last_rdata = uart_hist[1];
        idle_cycles(2, 1'b0);
        checks++; if (r_idle_bad !== 0) begin errors++; $display("FAIL b2b.no_retrigger got %0d busy cycles want 0", r_idle_bad); end
    endtask

    task automatic test_read_write_both;
        run_access(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0001, -1);
        checks++; if (r_rvalid_cnt !== 0 || r_bus_we !== 1'b1) begin errors++; $display("FAIL rw_both.as_store got rvalid=%0d we=%b want 0 1", r_rvalid_cnt, r_bus_we); end
        checks++; if (r_done_k !== DM_LAT + 1 || r_cs !== DM_LAT || r_bus_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rw_both.access got k=%0d cs=%0d %h", r_done_k, r_cs, r_bus_wdata); end
        checks++; if (r_rdata_done !== exp_last_rdata) begin errors++; $display("FAIL rw_both.rdata_kept got %h want %h", r_rdata_done, exp_last_rdata); end
    endtask

    task automatic test_stray_ack;
        idle_cycles(3, 1'b1);
        checks++; if (r_idle_bad !== 0) begin errors++; $display("FAIL stray_ack.idle got %0d busy cycles want 0", r_idle_bad); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk_i); #1;
        mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h44; dm_rdata_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        checks++; if (cs_dm_o !== 1'b1) begin errors++; $display("FAIL reset_mid.busy got cs=%b want 1", cs_dm_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (cs_dm_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_mid.async got cs=%b stall=%b want 0 0", cs_dm_o, stall_o); end
        checks++; if (rdata_o !== 32'h0 || rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_mid.outputs got %h v=%b want 0 0", rdata_o, rvalid_o); end
        @(posedge clk_i); #1;
        mem_read_i = 1'b0;
        #2 rst_i = 1'b0;
        exp_last_rdata = '0;
        run_access(1'b1, 1'b0, 32'h44, 32'h0, -1);
        checks++; if (r_done_k !== DM_LAT + 1 || r_rvalid_cnt !== 1 || r_rdata !== dm_hist[DM_LAT]) begin errors++; $display("FAIL reset_mid.recover got k=%0d n=%0d %h want %0d 1 %h", r_done_k, r_rvalid_cnt, r_rdata, DM_LAT + 1, dm_hist[DM_LAT]); end
        exp_last_rdata = dm_hist[DM_LAT];
    endtask

    // Random loads/stores, both targets, random ack delays and idle gaps.
    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic        rd, wr, is_uart, is_load;
            logic [31:0] a, wd, exp_data;
            int          ack_at, exp_k;
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a  = 32'($urandom);
            if ($urandom_range(0, 1) == 1) a = U_BASE | (a & 32'h0000_00FF);
            wd = 32'($urandom);
            ack_at  = int'($urandom_range(1, 6));
            is_uart = ((a & U_MASK) == U_BASE);
            is_load = rd && !wr;
            exp_k   = is_uart ? ack_at + 1 : DM_LAT + 1;
            run_access(rd, wr, a, wd, ack_at);
            exp_data = is_uart ? uart_hist[ack_at] : dm_hist[DM_LAT];
            checks++; if (r_done_k !== exp_k) begin errors++; $display("FAIL rand[%0d].latency got %0d want %0d", t, r_done_k, exp_k); end
            checks++; if (r_cs !== (is_uart ? 0 : DM_LAT) || r_req !== (is_uart ? ack_at : 0) || r_overlap !== 0) begin errors++; $display("FAIL rand[%0d].selects got cs=%0d req=%0d ov=%0d", t, r_cs, r_req, r_overlap); end
            checks++; if (r_bus_addr !== a || r_bus_we !== wr || (wr && r_bus_wdata !== wd)) begin errors++; $display("FAIL rand[%0d].bus got %h we=%b %h want %h %b %h", t, r_bus_addr, r_bus_we, r_bus_wdata, a, wr, wd); end
            checks++; if (r_rvalid_cnt !== (is_load ? 1 : 0) || r_err_cnt !== 0) begin errors++; $display("FAIL rand[%0d].rvalid got %0d err=%0d want %0d 0", t, r_rvalid_cnt, r_err_cnt, is_load ? 1 : 0); end
            if (is_load) exp_last_rdata = exp_data;
            checks++; if (r_rdata_done !== exp_last_rdata) begin errors++; $display("FAIL rand[%0d].rdata got %h want %h", t, r_rdata_done, exp_last_rdata); end
            if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        run_access(1'b1, 1'b0, 32'h8000_0008, 32'h0, -1);
        checks++; if (r_done_k !== TIMEOUT + 1 || r_req !== TIMEOUT) begin errors++; $display("FAIL timeout.latency got k=%0d req=%0d want %0d %0d", r_done_k, r_req, TIMEOUT + 1, TIMEOUT); end
        checks++; if (r_err_cnt !== 1 || bus_err_o !== 1'b1) begin errors++; $display("FAIL timeout.err got %0d/%b want 1/1", r_err_cnt, bus_err_o); end
        checks++; if (r_rvalid_cnt !== 1 || r_rdata !== 32'h0) begin errors++; $display("FAIL timeout.rdata got n=%0d %h want 1 0", r_rvalid_cnt, r_rdata); end
        exp_last_rdata = '0;
        idle_cycles(1, 1'b0);
        checks++; if (r_idle_bad !== 0) begin errors++; $display("FAIL timeout.err_pulse got %0d busy cycles want 0", r_idle_bad); end
    endtask
`else
    task automatic test_long_wait;
        run_access(1'b1, 1'b0, 32'h8000_0008, 32'h0, 100);
        checks++; if (r_done_k !== 101 || r_err_cnt !== 0) begin errors++; $display("FAIL long_wait got k=%0d err=%0d want 101 0", r_done_k, r_err_cnt); end
        checks++; if (r_rvalid_cnt !== 1 || r_rdata !== uart_hist[100]) begin errors++; $display("FAIL long_wait.data got n=%0d %h want 1 %h", r_rvalid_cnt, r_rdata, uart_hist[100]); end
        exp_last_rdata = uart_hist[100];
    endtask
`endif

    initial begin
        test_reset();
        test_dm_load();
        test_uart_store();
        test_back_to_back();
        test_read_write_both();
        test_stray_ack();
        test_reset_mid();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
